// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - OP_* : 7-bit base opcodes recognised by the decode stage
//   - imm_type_e : immediate encoding formats
//   - imm_type_of() : maps an opcode to its immediate format
//     (opcodes without an immediate map to IMM_I)
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr : instruction word (opcode selects the immediate format)
//   imm   : immediate, sign-extended to WIDTH
module imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] imm
);

  logic signed [31:0] imm_p0;

  always_comb begin
    imm_p0 = '0;
    case (imm_type_of(instr[6:0]))
      IMM_S:   imm_p0 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_p0 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
      IMM_U:   imm_p0 = {instr[31:12], 12'b0};
      IMM_J:   imm_p0 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
      default: imm_p0 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = WIDTH'(imm_p0);

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I instruction decode stage with ID/EX pipeline register.
//   clk, reset          : clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc, id_ready : fetch handshake
//   flush, ex_ready     : kill and back-pressure from EX
//   rf_addr_1/2         : combinational register-file read addresses
//   rf_data_1/2         : register-file read data (captured into ID/EX)
//   ex_*                : registered operands, indices and control for EX
// Optional macro ID_STALL_COUNT_EN adds stall_cycles / flush_count
// (32-bit wrap-around event counters).
module id_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_valid,
  input  logic [WIDTH-1:0]     if_instr,
  input  logic [WIDTH-1:0]     if_pc,
  output logic                 id_ready,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic [ADD_WIDTH-1:0] rf_addr_1,
  output logic [ADD_WIDTH-1:0] rf_addr_2,
  input  logic [WIDTH-1:0]     rf_data_1,
  input  logic [WIDTH-1:0]     rf_data_2,
  output logic                 ex_valid,
  output logic [WIDTH-1:0]     ex_pc,
  output logic [WIDTH-1:0]     ex_rs1_data,
  output logic [WIDTH-1:0]     ex_rs2_data,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [ADD_WIDTH-1:0] ex_rs1,
  output logic [ADD_WIDTH-1:0] ex_rs2,
  output logic [ADD_WIDTH-1:0] ex_rd,
  output logic [6:0]           ex_opcode,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7_5,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_illegal
`ifdef ID_STALL_COUNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);

  // ---- Stage p0: combinational decode of if_instr ----
  logic [6:0]           opcode_p0;
  logic [ADD_WIDTH-1:0] rd_p0, rs1_p0, rs2_p0;
  logic [WIDTH-1:0]     imm_p0;
  logic use_rs1_p0, use_rs2_p0, wr_p0, reg_write_p0;
  logic mem_rd_p0, mem_wr_p0, illegal_p0;
  logic haz, issue;

  assign opcode_p0 = if_instr[6:0];
  assign rd_p0     = ADD_WIDTH'(if_instr[11:7]);
  assign rs1_p0    = ADD_WIDTH'(if_instr[19:15]);
  assign rs2_p0    = ADD_WIDTH'(if_instr[24:20]);
  assign rf_addr_1 = rs1_p0;
  assign rf_addr_2 = rs2_p0;

  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (if_instr[31:0]),
    .imm   (imm_p0)
  );

  always_comb begin
    use_rs1_p0 = 1'b0;
    use_rs2_p0 = 1'b0;
    wr_p0      = 1'b0;
    mem_rd_p0  = 1'b0;
    mem_wr_p0  = 1'b0;
    illegal_p0 = 1'b0;
    case (opcode_p0)
      OP_R:      begin use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; wr_p0 = 1'b1; end
      OP_STORE:  begin use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; mem_wr_p0 = 1'b1; end
      OP_BRANCH: begin use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; end
      OP_IMM:    begin use_rs1_p0 = 1'b1; wr_p0 = 1'b1; end
      OP_LOAD:   begin use_rs1_p0 = 1'b1; wr_p0 = 1'b1; mem_rd_p0 = 1'b1; end
      OP_JALR:   begin use_rs1_p0 = 1'b1; wr_p0 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: wr_p0 = 1'b1;
      default:   illegal_p0 = 1'b1;
    endcase
  end

  // Writes to x0 are architecturally discarded, so never request them.
  assign reg_write_p0 = wr_p0 & (rd_p0 != '0);

  // Only a load still sitting in ID/EX can stall; its bubble clears
  // ex_mem_read, so the stall self-terminates after one cycle.
  assign haz = ex_valid & ex_mem_read & (ex_rd != '0) & if_valid &
               ((use_rs1_p0 & (rs1_p0 == ex_rd)) | (use_rs2_p0 & (rs2_p0 == ex_rd)));

  assign id_ready = ex_ready & ~haz & ~flush;
  assign issue    = id_ready & if_valid;

  // ---- Stage p1: ID/EX pipeline register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (ex_ready) begin
      ex_valid     <= issue;
      ex_reg_write <= issue & reg_write_p0;
      ex_mem_read  <= issue & mem_rd_p0;
      ex_mem_write <= issue & mem_wr_p0;
      ex_illegal   <= issue & illegal_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7_5 <= 1'b0;
    end else if (issue) begin
      ex_pc       <= if_pc;
      ex_rs1_data <= rf_data_1;
      ex_rs2_data <= rf_data_2;
      ex_imm      <= imm_p0;
      ex_rs1      <= rs1_p0;
      ex_rs2      <= rs2_p0;
      ex_rd       <= rd_p0;
      ex_opcode   <= opcode_p0;
      ex_funct3   <= if_instr[14:12];
      ex_funct7_5 <= if_instr[30];
    end
  end

`ifdef ID_STALL_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (haz)   stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam logic [6:0] L_R = 7'b0110011, L_IMM = 7'b0010011, L_LOAD = 7'b0000011;
  localparam logic [6:0] L_STORE = 7'b0100011, L_BRANCH = 7'b1100011, L_JAL = 7'b1101111;
  localparam logic [6:0] L_JALR = 7'b1100111, L_LUI = 7'b0110111, L_AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic reset;
  logic if_valid, flush, ex_ready, id_ready;
  logic [31:0] if_instr, if_pc, rf_data_1, rf_data_2;
  logic [4:0] rf_addr_1, rf_addr_2, ex_rs1, ex_rs2, ex_rd;
  logic ex_valid, ex_funct7_5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
`ifdef ID_STALL_COUNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  logic [31:0] regs [32];
  assign rf_data_1 = regs[rf_addr_1];
  assign rf_data_2 = regs[rf_addr_2];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
`ifdef ID_STALL_COUNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, rw, mr, mw, ill, imm_chk, u1, u2;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err = 0;
  bit   m_valid = 1'b0;
  bit   m_load = 1'b0;
  logic [4:0] m_rd = '0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference decode: what EX should see for an accepted instruction.
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bit writes;
    writes = 1'b0;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[30];
    e.d1 = regs[ins[19:15]]; e.d2 = regs[ins[24:20]];
    e.u1 = 1'b0; e.u2 = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
    e.imm = '0; e.imm_chk = 1'b1;
    case (ins[6:0])
      L_R:      begin e.u1 = 1; e.u2 = 1; writes = 1; e.imm_chk = 0; end
      L_IMM, L_JALR: begin e.u1 = 1; writes = 1; e.imm = int'($signed(ins[31:20])); end
      L_LOAD:   begin e.u1 = 1; writes = 1; e.mr = 1; e.imm = int'($signed(ins[31:20])); end
      L_STORE:  begin e.u1 = 1; e.u2 = 1; e.mw = 1;
                      e.imm = int'($signed({ins[31:25], ins[11:7]})); end
      L_BRANCH: begin e.u1 = 1; e.u2 = 1;
                      e.imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2; end
      L_LUI, L_AUIPC: begin writes = 1; e.imm = {ins[31:12], 12'h000}; end
      L_JAL:    begin writes = 1;
                      e.imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2; end
      default:  begin e.ill = 1; e.imm_chk = 0; end
    endcase
    e.rw = writes && (e.rd != 5'd0);
    return e;
  endfunction

  // One cycle of stimulus; called just after a rising edge.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl, output bit acc);
    exp_t e;
    bit haz, exp_rdy;
    if_valid = iv; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
    #3;
    e = predict(ins, pc);
    haz = m_valid && m_load && (m_rd != 5'd0) && iv &&
          ((e.u1 && e.rs1 == m_rd) || (e.u2 && e.rs2 == m_rd));
    exp_rdy = rdy && !haz && !fl;
    chk("id_ready", 32'(id_ready), 32'(exp_rdy));
    chk("ex_valid_state", 32'(ex_valid), 32'(m_valid));
    chk("rf_addr_1", 32'(rf_addr_1), 32'(ins[19:15]));
    chk("rf_addr_2", 32'(rf_addr_2), 32'(ins[24:20]));
    acc = exp_rdy && iv;
    if (haz) m_stall++;
    if (fl) m_flush++;
    @(posedge clk);
    if (fl) begin
      if (!rdy && m_valid && sb.size() > 0) void'(sb.pop_back());
      m_valid = 1'b0; m_load = 1'b0;
    end else if (rdy) begin
      m_valid = acc; m_load = acc && e.mr; m_rd = e.rd;
      if (acc) sb.push_back(e);
    end
    #1;
  endtask

  // Monitor: EX consumes the ID/EX content whenever it is valid and EX is ready.
  always @(negedge clk) begin
    if (reset === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'(ex_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("ex_pc", ex_pc, mon_e.pc);
        chk("ex_rs1_data", ex_rs1_data, mon_e.d1);
        chk("ex_rs2_data", ex_rs2_data, mon_e.d2);
        if (mon_e.imm_chk) chk("ex_imm", ex_imm, mon_e.imm);
        chk("ex_regs", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({mon_e.rs1, mon_e.rs2, mon_e.rd}));
        chk("ex_fields", 32'({ex_opcode, ex_funct3, ex_funct7_5}),
            32'({mon_e.op, mon_e.f3, mon_e.f7}));
        chk("ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}),
            32'({mon_e.rw, mon_e.mr, mon_e.mw, mon_e.ill}));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 9))
      0: ins[6:0] = L_R;      1: ins[6:0] = L_IMM;    2: ins[6:0] = L_LOAD;
      3: ins[6:0] = L_STORE;  4: ins[6:0] = L_BRANCH; 5: ins[6:0] = L_JAL;
      6: ins[6:0] = L_JALR;   7: ins[6:0] = L_LUI;    8: ins[6:0] = L_AUIPC;
      default: ins[6:0] = 7'b1111111;
    endcase
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    return ins;
  endfunction

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit cur_v;
    logic [31:0] cur_i, cur_pc, pc_ctr;
    for (int r = 0; r < 32; r++) regs[r] = (r == 0) ? 32'd0 : $urandom;
    reset = 1'b0; if_valid = 0; if_instr = '0; if_pc = '0; ex_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    chk("rst_ex_data", ex_rs1_data | ex_rs2_data, 32'd0);
    chk("rst_ex_idx", 32'({ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7_5}), 32'd0);
    chk("rst_ex_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}), 32'd0);
`ifdef ID_STALL_COUNT_EN
    chk("rst_counters", stall_cycles | flush_count, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // addi x1,x0,-1
    step(1, 32'hFFF00093, 32'h100, 1, 0, acc);
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_rw", 32'(ex_reg_write), 32'd1);

    // lw x5,0(x1) then add x6,x5,x2: one bubble
    step(1, 32'h0000A283, 32'h104, 1, 0, acc);
    step(1, 32'h00228333, 32'h108, 1, 0, acc);
    chk("loaduse_bubble", 32'(ex_valid), 32'd0);
`ifdef ID_STALL_COUNT_EN
    chk("loaduse_stall_count", stall_cycles, 32'd1);
`endif
    step(1, 32'h00228333, 32'h108, 1, 0, acc);
    chk("loaduse_issue_valid", 32'(ex_valid), 32'd1);
    chk("loaduse_issue_rs1", 32'(ex_rs1), 32'd5);

    // lw x0 then add reading x0: no stall
    step(1, 32'h0000A003, 32'h10C, 1, 0, acc);
    step(1, 32'h00200333, 32'h110, 1, 0, acc);
    chk("x0_load_nostall", 32'(ex_valid), 32'd1);

    // hold with a valid add in ID/EX
    step(1, 32'h00228333, 32'h200, 1, 0, acc);
    for (int h = 0; h < 3; h++) begin
      step(1, 32'h00A00393, 32'h204, 0, 0, acc);
      chk("hold_pc", ex_pc, 32'h200);
      chk("hold_rd_valid", 32'({ex_rd, ex_valid}), 32'({5'd6, 1'b1}));
    end
    step(1, 32'h00A00393, 32'h204, 1, 0, acc);

    // flush while a load-use hazard is pending
    step(1, 32'h0000A283, 32'h208, 1, 0, acc);
    step(1, 32'h00228333, 32'h20C, 1, 1, acc);
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_mem_read", 32'(ex_mem_read), 32'd0);
    step(1, 32'h00228333, 32'h20C, 1, 0, acc);
    chk("postflush_issue", 32'({ex_valid, ex_rs1}), 32'({1'b1, 5'd5}));

    // illegal opcode
    step(1, 32'hFFFFFFFF, 32'h210, 1, 0, acc);
    chk("illegal_flags", 32'({ex_illegal, ex_valid, ex_reg_write}), 32'b110);

    // reset in the middle of a stall
    step(1, 32'h0000A283, 32'h214, 1, 0, acc);
    if_valid = 1; if_instr = 32'h00228333; if_pc = 32'h218; ex_ready = 1; flush = 0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
    chk("midrst_mem_read", 32'(ex_mem_read), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    m_valid = 0; m_load = 0; m_rd = '0; m_stall = 0; m_flush = 0;
`ifdef ID_STALL_COUNT_EN
    chk("midrst_counters", stall_cycles | flush_count, 32'd0);
`endif

    // randomized traffic; fetch keeps offering an instruction until taken
    cur_v = 0; acc = 0; pc_ctr = 32'h1000; cur_i = '0; cur_pc = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!cur_v || acc) begin
        cur_i = rand_instr(); cur_pc = pc_ctr; pc_ctr += 32'd4;
        cur_v = ($urandom_range(0, 99) < 85);
      end
      step(cur_v, cur_i, cur_pc, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 8), acc);
    end
    for (int d = 0; d < 3; d++) step(0, 32'h0, 32'h0, 1, 0, acc);
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef ID_STALL_COUNT_EN
    chk("stall_cycles", stall_cycles, 32'(m_stall));
    chk("flush_count", flush_count, 32'(m_flush));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
